// File: rtl/alu_hex_engine.sv
// Switch-driven ALU (add/sub/mul/restoring div) with a registered result shown on active-low hex digits.
// Optional build macro: ALU_LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module alu_hex_engine #(
  parameter int W          = 4,
  parameter int NUM_DIGITS = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [W-1:0]            SW_A,
  input  logic [W-1:0]            SW_B,
  input  logic [1:0]              SW_SEL,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [2*W-1:0]          RESULT,
  output logic [8*NUM_DIGITS-1:0] HEX,
  output logic [3:0]              LED
);

  localparam int CW = $clog2(W + 1);
  localparam int PW = (4 * NUM_DIGITS > 2 * W) ? 4 * NUM_DIGITS : 2 * W;

  typedef enum logic [1:0] {IDLE, EXEC, DIV, FIN} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [1:0]      sel_q, sel_d;
  logic [W-1:0]    rem_q, rem_d, quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [2*W-1:0]  result_q, result_d;
  logic [3:0]      led_q, led_d;

  logic [W:0]      sum_s;
  logic [W-1:0]    diff_s;
  logic [2*W-1:0]  prod_s;
  logic [2*W-1:0]  exec_res_s;
  logic            carry_s, borrow_s, dz_s;
  logic [W:0]      trial_s, trial_sub_s;
  logic            ge_s;
  logic [W-1:0]    rem_step_s, quo_step_s;
  logic [PW-1:0]   pad_s;
  logic [8*NUM_DIGITS-1:0] hex_s;

  function automatic logic [7:0] seg7(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;  4'h1: seg = 8'hF9;  4'h2: seg = 8'hA4;  4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;  4'h5: seg = 8'h92;  4'h6: seg = 8'h82;  4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;  4'h9: seg = 8'h90;  4'hA: seg = 8'h88;  4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;  4'hD: seg = 8'hA1;  4'hE: seg = 8'h86;  4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  // Single-cycle arithmetic on the latched operands
  always_comb begin
    sum_s      = {1'b0, a_q} + {1'b0, b_q};
    diff_s     = a_q - b_q;
    prod_s     = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    exec_res_s = '0;
    carry_s    = 1'b0;
    borrow_s   = 1'b0;
    dz_s       = 1'b0;
    case (sel_q)
      2'b00: begin
        exec_res_s[W:0] = sum_s;
        carry_s         = sum_s[W];
      end
      2'b01: begin
        exec_res_s[W-1:0] = diff_s;
        borrow_s          = (a_q < b_q);
      end
      2'b10: exec_res_s = prod_s;
      2'b11: begin
        exec_res_s = {a_q, {W{1'b1}}};
        dz_s       = 1'b1;
      end
      default: exec_res_s = '0;
    endcase
  end

  // One restoring step; remainder stays below B, so the top bit of the trial difference is the sign
  always_comb begin
    trial_s     = {rem_q, quo_q[W-1]};
    trial_sub_s = trial_s - {1'b0, b_q};
    ge_s        = ~trial_sub_s[W];
    rem_step_s  = ge_s ? trial_sub_s[W-1:0] : trial_s[W-1:0];
    quo_step_s  = {quo_q[W-2:0], ge_s};
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    led_d    = led_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          a_d    = SW_A;
          b_d    = SW_B;
          sel_d  = SW_SEL;
          rem_d  = '0;
          quo_d  = SW_A;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (SW_SEL == 2'b11 && SW_B != '0) begin
            state_d = DIV;
          end else begin
            state_d = EXEC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        result_d = exec_res_s;
        led_d    = {(exec_res_s == '0), dz_s, borrow_s, carry_s};
        state_d  = FIN;
      end
      DIV: begin
        rem_d = rem_step_s;
        quo_d = quo_step_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          result_d = {rem_step_s, quo_step_s};
          led_d    = {({rem_step_s, quo_step_s} == '0), 3'b000};
          state_d  = FIN;
        end else begin
          state_d = DIV;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= 2'b00;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      led_q    <= 4'b1000;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      led_q    <= led_d;
    end
  end

  assign pad_s = PW'(result_q);

  // Hex digit decode straight from the result register
  always_comb begin
    hex_s = '0;
`ifdef ALU_LEADING_ZERO_BLANK_EN
    begin : g_lzb
      logic seen_s;
      seen_s = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
        if (pad_s[4*i +: 4] != 4'h0) begin
          seen_s = 1'b1;
        end else begin
          seen_s = seen_s;
        end
        if (seen_s || i == 0) begin
          hex_s[8*i +: 8] = seg7(pad_s[4*i +: 4]);
        end else begin
          hex_s[8*i +: 8] = 8'hFF;
        end
      end
    end
`else
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (4 * i < 2 * W) begin
        hex_s[8*i +: 8] = seg7(pad_s[4*i +: 4]);
      end else begin
        hex_s[8*i +: 8] = 8'hFF;
      end
    end
`endif
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;
  assign LED    = led_q;
  assign HEX    = hex_s;

endmodule

// File: tb/tb_alu_hex_engine.sv
// Directed scoreboard bench for alu_hex_engine (W=4, NUM_DIGITS=2).
module tb_alu_hex_engine;

  logic        CLK, RST, START;
  logic [3:0]  SW_A, SW_B;
  logic [1:0]  SW_SEL;
  logic        BUSY, DONE;
  logic [7:0]  RESULT;
  logic [15:0] HEX;
  logic [3:0]  LED;

  int checks   = 0;
  int failures = 0;
  logic [11:0] sb[$];

  alu_hex_engine #(.W(4), .NUM_DIGITS(2)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SW_A(SW_A), .SW_B(SW_B), .SW_SEL(SW_SEL),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .HEX(HEX), .LED(LED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: returns {led[3:0], result[7:0]}
  function automatic logic [11:0] model(input int a, input int b, input int sel);
    int r;
    logic c, bo, dz;
    c = 1'b0; bo = 1'b0; dz = 1'b0;
    case (sel)
      0: begin r = a + b; c = (r > 15); end
      1: begin r = (a - b) & 15; bo = (a < b); end
      2: r = a * b;
      default: begin
        if (b == 0) begin r = (a << 4) | 15; dz = 1'b1; end
        else r = ((a % b) << 4) | (a / b);
      end
    endcase
    return {(r == 0), dz, bo, c, 8'(r)};
  endfunction

  function automatic logic [7:0] seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [15:0] hex_model(input logic [7:0] r);
    logic [7:0] hi;
    hi = seg(r[7:4]);
`ifdef ALU_LEADING_ZERO_BLANK_EN
    if (r[7:4] == 4'h0) hi = 8'hFF;
`endif
    return {hi, seg(r[3:0])};
  endfunction

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel, input string tag);
    logic [11:0] e;
    logic [7:0]  prev;
    int lat;
    e    = model(a, b, sel);
    lat  = (sel == 2'b11 && b != 4'd0) ? 4 : 1;
    prev = RESULT;
    SW_A = a; SW_B = b; SW_SEL = sel; START = 1'b1;
    sb.push_back(e);
    tick();
    chk({tag, "_busy_start"}, BUSY, 1);
    START = 1'b0; SW_A = ~a; SW_B = ~b; SW_SEL = ~sel;
    for (int k = 1; k < lat; k++) begin
      START = (k == 1);
      tick();
      chk({tag, "_result_hold"}, RESULT, prev);
      chk({tag, "_busy_mid"}, BUSY, 1);
    end
    START = 1'b0;
    tick();
    chk({tag, "_result"}, RESULT, sb[0][7:0]);
    chk({tag, "_led"}, LED, sb[0][11:8]);
    chk({tag, "_busy_wr"}, BUSY, 1);
    chk({tag, "_done_early"}, DONE, 0);
    tick();
    chk({tag, "_done"}, DONE, 1);
    chk({tag, "_busy_clr"}, BUSY, 0);
    e = sb.pop_front();
    chk({tag, "_sb_result"}, RESULT, e[7:0]);
    chk({tag, "_hex"}, HEX, hex_model(e[7:0]));
    tick();
    chk({tag, "_done_pulse"}, DONE, 0);
    chk({tag, "_idle"}, BUSY, 0);
  endtask

  initial begin
    int done_seen;
    RST = 1'b1; START = 1'b0; SW_A = 4'd0; SW_B = 4'd0; SW_SEL = 2'b00;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    chk("rst_result", RESULT, 8'h00);
    chk("rst_hex", HEX, hex_model(8'h00));
    chk("rst_led", LED, 4'b1000);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);

    run_op(4'd9, 4'd8, 2'b00, "add");
    chk("add_carry", LED[0], 1);
    chk("add_hex_lit", HEX, 16'hF9F9);
    run_op(4'd3, 4'd5, 2'b01, "sub");
    chk("sub_lit", RESULT, 8'h0E);
    run_op(4'd15, 4'd15, 2'b10, "mul");
    chk("mul_hex_lit", HEX, 16'h86F9);
    run_op(4'd13, 4'd4, 2'b11, "div");
    chk("div_lit", RESULT, 8'h13);
    run_op(4'd7, 4'd0, 2'b11, "divz");
    chk("divz_lit", RESULT, 8'h7F);
    chk("divz_flag", LED[2], 1);
    run_op(4'd5, 4'd5, 2'b01, "subzero");
    run_op(4'd0, 4'd3, 2'b11, "divzero");
    run_op(4'd15, 4'd1, 2'b00, "addmax");
    run_op(4'd14, 4'd3, 2'b11, "div2");
    run_op(4'd2, 4'd3, 2'b00, "add5");

    // START held high: second op launches three cycles after the first
    SW_A = 4'd1; SW_B = 4'd1; SW_SEL = 2'b00; START = 1'b1;
    sb.push_back(model(1, 1, 0));
    tick();
    chk("b2b_busy0", BUSY, 1);
    tick();
    chk("b2b_res0", RESULT, sb[0][7:0]);
    SW_A = 4'd4;
    sb.push_back(model(4, 1, 0));
    tick();
    chk("b2b_done0", DONE, 1);
    chk("b2b_pop0", RESULT, sb.pop_front());
    tick();
    START = 1'b0;
    chk("b2b_retrig", BUSY, 1);
    chk("b2b_done_clr", DONE, 0);
    tick();
    chk("b2b_res1", RESULT, sb[0][7:0]);
    tick();
    chk("b2b_done1", DONE, 1);
    chk("b2b_pop1", RESULT, sb.pop_front());
    tick();
    chk("b2b_idle", BUSY, 0);

    // Reset in the middle of a division discards it
    SW_A = 4'd13; SW_B = 4'd4; SW_SEL = 2'b11; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    #1;
    chk("mrst_result", RESULT, 8'h00);
    chk("mrst_busy", BUSY, 0);
    chk("mrst_led", LED, 4'b1000);
    chk("mrst_hex", HEX, hex_model(8'h00));
    tick();
    RST = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (DONE) done_seen++;
    end
    chk("mrst_no_done", done_seen, 0);
    chk("mrst_result_after", RESULT, 8'h00);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_hex_engine.md
# alu_hex_engine

Parametrised successor to the switch-driven mode-select and seven-segment datapath. The block latches two W-bit operands and a 2-bit mode on a start request, then computes add, sub, mul or div. Division is a multi-cycle restoring divider. The result is held in a register and driven as hex digits to NUM_DIGITS active-low seven-segment displays, with status flags on LEDs. It sits between the board switches/keys and the HEX/LED pins.

## Interface
- W, default 4: operand width, 2..16.
- NUM_DIGITS, default 2: number of seven-segment digits driven.
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous and active-high.
- START  input  1  start request; level-sampled.
- SW_A  input  W  operand A, unsigned.
- SW_B  input  W  operand B, unsigned.
- SW_SEL  input  2  mode select: 00 add, 01 sub, 10 mul, 11 div.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse when RESULT updates.
- RESULT  output  2W  registered result.
- HEX  output  8*NUM_DIGITS  segment codes, active-low.
  - HEX[8i+7:8i] is digit i; bit 7 is dp and is always 1.
- LED  output  4  status flags:
  - [0] carry
  - [1] borrow
  - [2] divide-by-zero
  - [3] result zero

## Operation
- FSM states: IDLE, EXEC, DIV, FIN.
  - IDLE with START=1: latch SW_A, SW_B and SW_SEL; set BUSY.
    - If mode is div and B≠0, go to DIV.
    - Otherwise go to EXEC.
  - EXEC: write RESULT and flags, then go to FIN.
  - DIV: one restoring step per cycle, for exactly W cycles, then FIN.
  - FIN: pulse DONE, clear BUSY, go to IDLE.
- START while not in IDLE is ignored. Switch changes after the latch have no effect on the operation in progress.
- Arithmetic (upper RESULT bits are zero-filled):
  - add: RESULT = A+B, W+1 bits; LED[0] = bit W.
  - sub: RESULT[W-1:0] = A−B mod 2^W; LED[1] = (A<B).
  - mul: RESULT = A*B, full 2W bits.
  - div: RESULT = {remainder[W-1:0], quotient[W-1:0]}.
  - div with B=0 takes the EXEC path: quotient all ones, remainder = A, LED[2]=1.
- LED[3] = (RESULT==0). Flags that do not apply to the current mode are cleared on each RESULT write.
- HEX digit i shows the hex nibble RESULT[4i+3:4i], decoded combinationally from the RESULT register.
  - Digits with 4i ≥ 2W show blank (8'hFF).
  - Encoding 0–F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Reset (asynchronous, any state, including mid-division):
  - state IDLE; BUSY=0, DONE=0, RESULT=0, LED=4'b1000.
  - Divider registers are cleared; a partial division is discarded and never reaches RESULT.

## Timing
- Edge numbering: START is sampled high at edge N, and BUSY=1 after edge N.
- add, sub, mul and div-by-zero: RESULT and LEDs update at edge N+1; DONE=1 and BUSY=0 after edge N+2.
- div with B≠0: RESULT updates at edge N+W; DONE pulses after edge N+W+1.
- DONE is high for exactly one cycle.
- A START held high re-triggers at the first IDLE cycle, giving back-to-back operations every 3 cycles (non-div).
- HEX follows RESULT in the same cycle, with no extra register.

## Configuration
- ALU_LEADING_ZERO_BLANK_EN defined:
  - Digits above the most significant nonzero nibble show 8'hFF.
  - Digit 0 always shows a value; at reset it shows "0" (C0) with all other digits blank.
- Undefined: every digit with 4i < 2W shows its nibble, including leading zeros.

## Test plan
All cases use W=4, NUM_DIGITS=2, macro undefined unless noted.
- Reset: RST pulse → RESULT=0x00, HEX=16'hC0C0, LED=4'b1000, BUSY=0.
- add: A=9, B=8, SEL=00, START one cycle → after edge N+1, RESULT=0x11 and LED[0]=1; DONE pulse at N+2; HEX=16'hF9F9.
- sub then mul:
  - A=3, B=5, SEL=01 → RESULT=0x0E, LED[1]=1.
  - A=15, B=15, SEL=10 → RESULT=0xE1, HEX=16'h86F9.
- div:
  - A=13, B=4, SEL=11 → RESULT=0x13 at edge N+4; BUSY high for 5 cycles.
  - A=7, B=0 → RESULT=0x7F, LED[2]=1 at edge N+1.
- Ignore and reset:
  - START re-asserted during DIV is ignored.
  - RST asserted at cycle 2 of a division → RESULT=0x00 immediately; no DONE pulse afterward.
- With ALU_LEADING_ZERO_BLANK_EN: result 0x05 → HEX=16'hFF92; reset → HEX=16'hFFC0.
